// File: rtl/result_ascii_tx.sv
// result_ascii_tx: prints a binary result word as decimal ASCII on a byte
// stream, most significant digit first, followed by TERM_CHAR.
// Binary-to-BCD runs iteratively (shift-add-3), one input bit per cycle.
// Optional feature macro: RESULT_TX_SIGNED_EN. When defined, result_in is
// two's complement and negative values are prefixed with '-'.
//
// Handshake rule (both ports): a transfer happens on a posedge clk where
// valid && ready are both high. char_out/char_valid are registered, hold
// steady until char_ready, and never depend combinationally on char_ready.
module result_ascii_tx #(
  parameter int          WIDTH     = 64,
  parameter logic [7:0]  TERM_CHAR = 8'd10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] result_in,
  input  logic             result_valid,
  output logic             result_ready,
  output logic [7:0]       char_out,
  output logic             char_valid,
  input  logic             char_ready,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  localparam int NDIG = (WIDTH * 3) / 10 + 1;
  localparam int BW   = 4 * NDIG;
  localparam int PW   = $clog2(NDIG + 1);
  localparam int CW   = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVERT = 3'd1,
    SIGN    = 3'd2,
    EMIT    = 3'd3,
    TERM    = 3'd4
  } state_t;

  state_t           state;
  logic [BW-1:0]    bcd;
  logic [BW-1:0]    bcd_adj;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_m1;
  logic [PW-1:0]    msnz;
  logic [3:0]       nib_msnz;
  logic [3:0]       nib_ptr_m1;
`ifdef RESULT_TX_SIGNED_EN
  logic             neg;
  logic [3:0]       nib_ptr;
`endif

  assign state_dbg = state;
  assign ptr_m1    = ptr - 1'b1;

  // Pick one BCD digit out of the packed digit register.
  function automatic logic [3:0] nib_at(input logic [BW-1:0] b, input logic [PW-1:0] i);
    return b[{i, 2'b00} +: 4];
  endfunction

  // Add-3 correction: every digit >= 5 gets +3 before the next left shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Most significant nonzero digit; stays 0 for a zero value so "0" prints.
  always_comb begin
    msnz = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd[4*i +: 4] != 4'd0) msnz = PW'(i);
    end
  end

  // Digit lookups for the character that goes out next.
  always_comb begin
    nib_msnz   = nib_at(bcd, msnz);
    nib_ptr_m1 = nib_at(bcd, ptr_m1);
`ifdef RESULT_TX_SIGNED_EN
    nib_ptr    = nib_at(bcd, ptr);
`endif
  end

  // Main control FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      result_ready <= 1'b0;
      char_valid   <= 1'b0;
      char_out     <= 8'h00;
      busy         <= 1'b0;
      bcd          <= '0;
      shreg        <= '0;
      cnt          <= '0;
      ptr          <= '0;
`ifdef RESULT_TX_SIGNED_EN
      neg          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (result_ready && result_valid) begin
            bcd          <= '0;
            cnt          <= CW'(WIDTH);
            result_ready <= 1'b0;
            busy         <= 1'b1;
            state        <= CONVERT;
`ifdef RESULT_TX_SIGNED_EN
            // Two's complement negate; the most negative value maps to its exact magnitude.
            shreg        <= result_in[WIDTH-1] ? (~result_in + 1'b1) : result_in;
            neg          <= result_in[WIDTH-1];
`else
            shreg        <= result_in;
`endif
          end else begin
            result_ready <= 1'b1;
          end
        end

        CONVERT: begin
          if (cnt != '0) begin
            {bcd, shreg} <= {bcd_adj, shreg} << 1;
            cnt          <= cnt - 1'b1;
          end else begin
            // All bits shifted in: BCD is final, start printing.
            ptr        <= msnz;
            char_valid <= 1'b1;
`ifdef RESULT_TX_SIGNED_EN
            if (neg) begin
              state    <= SIGN;
              char_out <= 8'h2D;
            end else begin
              state    <= EMIT;
              char_out <= 8'h30 + {4'h0, nib_msnz};
            end
`else
            state      <= EMIT;
            char_out   <= 8'h30 + {4'h0, nib_msnz};
`endif
          end
        end

`ifdef RESULT_TX_SIGNED_EN
        SIGN: begin
          if (char_ready) begin
            state    <= EMIT;
            char_out <= 8'h30 + {4'h0, nib_ptr};
          end
        end
`endif

        EMIT: begin
          if (char_ready) begin
            if (ptr == '0) begin
              state    <= TERM;
              char_out <= TERM_CHAR;
            end else begin
              ptr      <= ptr_m1;
              char_out <= 8'h30 + {4'h0, nib_ptr_m1};
            end
          end
        end

        TERM: begin
          if (char_ready) begin
            state        <= IDLE;
            char_valid   <= 1'b0;
            busy         <= 1'b0;
            result_ready <= 1'b1;
          end
        end

        default: begin
          state        <= IDLE;
          char_valid   <= 1'b0;
          busy         <= 1'b0;
          result_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_ascii_tx.sv
// Testbench for result_ascii_tx: scoreboard of expected characters built
// from a division-by-ten decimal model, checked as characters transfer.
module tb_result_ascii_tx;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] result_in;
  logic         result_valid;
  logic         result_ready;
  logic [7:0]   char_out;
  logic         char_valid;
  logic         char_ready;
  logic         busy;
  logic [2:0]   state_dbg;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  int cyc = 0;
  int acc_cyc = 0;
  int first_cyc = 0;
  int last_pop_cyc = 0;
  int pop_cnt = 0;
  bit seen_first = 1'b0;
  bit rand_rdy = 1'b0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_char = 8'h00;

  result_ascii_tx #(.WIDTH(W), .TERM_CHAR(8'd10)) dut (
    .clk          (clk),
    .rst          (rst),
    .result_in    (result_in),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .char_out     (char_out),
    .char_valid   (char_valid),
    .char_ready   (char_ready),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // Sink ready: always 1, or pseudo-random when rand_rdy is set.
  initial begin
    char_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      char_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (char_valid !== 1'b1 || char_out !== prev_char) begin
            errors++;
            $display("FAIL stall_stable: valid=%b char=%h, required valid=1 char=%h",
                     char_valid, char_out, prev_char);
          end
        end
        if (char_valid === 1'b1 && !seen_first) begin
          seen_first = 1'b1;
          first_cyc  = cyc;
        end
        if (char_valid === 1'b1 && char_ready === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_char: got %h, required no character", char_out);
          end else begin
            e = exp_q.pop_front();
            if (char_out !== e) begin
              errors++;
              $display("FAIL char: got %h, required %h", char_out, e);
            end
          end
          pop_cnt++;
          last_pop_cyc = cyc;
        end
        prev_stall = (char_valid === 1'b1) && (char_ready !== 1'b1);
        prev_char  = char_out;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_expected(input logic [W-1:0] v);
    logic [W-1:0] m;
    logic [7:0]   d[$];
    m = v;
`ifdef RESULT_TX_SIGNED_EN
    if (v[W-1]) begin
      exp_q.push_back(8'h2D);
      m = -v;
    end
`endif
    do begin
      d.push_front(8'h30 + 8'(m % 10));
      m = m / 10;
    end while (m != 0);
    foreach (d[i]) exp_q.push_back(d[i]);
    exp_q.push_back(8'h0A);
  endtask

  task automatic send(input logic [W-1:0] v);
    int t;
    push_expected(v);
    t = 0;
    @(negedge clk);
    while (result_ready !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: result_ready=%b, required 1", result_ready);
    end
    result_in    = v;
    result_valid = 1'b1;
    seen_first   = 1'b0;
    @(posedge clk);
    #1;
    result_valid = 1'b0;
    acc_cyc      = cyc;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      #1;
      t++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d chars outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    checks++;
    if (result_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: ready=%b busy=%b, required ready=1 busy=0", name, result_ready, busy);
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if (result_ready !== 1'b0 || char_valid !== 1'b0 || char_out !== 8'h00 ||
        busy !== 1'b0 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL %s: ready=%b valid=%b char=%h busy=%b state=%0d, required 0 0 00 0 0",
               name, result_ready, char_valid, char_out, busy, state_dbg);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    result_valid = 1'b0;
    result_in = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset_values");
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (result_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise: ready=%b, required 1", result_ready);
    end
  endtask

  task automatic test_zero();
    send('0);
    drain("zero");
  endtask

  task automatic test_1234();
    int p0;
    p0 = pop_cnt;
    send(W'(1234));
    // result_valid while busy must be ignored
    @(negedge clk);
    result_in    = W'(99);
    result_valid = 1'b1;
    repeat (5) @(negedge clk);
    result_valid = 1'b0;
    drain("d1234");
    checks++;
    if (first_cyc - acc_cyc != W + 1) begin
      errors++;
      $display("FAIL latency: %0d cycles, required %0d", first_cyc - acc_cyc, W + 1);
    end
    checks++;
    if (pop_cnt - p0 != 5 || last_pop_cyc - first_cyc != 4) begin
      errors++;
      $display("FAIL no_gaps: %0d chars over %0d cycles, required 5 over 4",
               pop_cnt - p0, last_pop_cyc - first_cyc);
    end
  endtask

  task automatic test_max();
    send({W{1'b1}});
    drain("max");
  endtask

  task automatic test_stall();
    rand_rdy = 1'b1;
    send(W'(907));
    drain("stall");
    rand_rdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    int p0;
    int t;
    p0 = pop_cnt;
    send(W'(56789));
    t = 0;
    while (pop_cnt - p0 < 2 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      checks++;
      errors++;
      $display("FAIL midreset_wait: %0d chars seen, required 2", pop_cnt - p0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_reset_vals("midreset_async");
    @(negedge clk);
    check_reset_vals("midreset_held");
    rst = 1'b0;
    send(W'(42));
    drain("after_reset");
  endtask

  task automatic test_fffb();
    send(64'hFFFF_FFFF_FFFF_FFFB);
    drain("fffb");
  endtask

  task automatic test_back_to_back();
    send(W'(7));
    send(W'(8));
    drain("b2b");
  endtask

  initial begin
    test_reset();
    test_zero();
    test_1234();
    test_max();
    test_stall();
    test_reset_mid();
    test_fffb();
    test_back_to_back();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || char_valid !== 1'b0) begin
      errors++;
      $display("FAIL final_quiet: queue=%0d valid=%b, required 0 0", exp_q.size(), char_valid);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
